// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   chunk_width()   : bits handled by each pipeline stage
//   FLAG_*_BIT      : bit positions of {cout, of, zero} in the EX-stage status word
package addsub_pkg;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  localparam int unsigned FLAG_ZERO_BIT = 0;
  localparam int unsigned FLAG_OF_BIT   = 1;
  localparam int unsigned FLAG_COUT_BIT = 2;
  localparam int unsigned FLAG_W        = 3;

  typedef logic [FLAG_W-1:0] status_t;

endpackage

// File: rtl/fa_nbit.sv
// W-bit ripple adder chunk.
//   a, b  : chunk operands (b already inverted by the caller for subtract)
//   cin   : carry in
//   sum   : chunk sum
//   cout  : carry out of the chunk MSB
//   of    : carry into chunk MSB XOR carry out (signed overflow if this is the top chunk)
module fa_nbit #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         of
);

  logic [W:0] full;
  logic       c_msb;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // carry into the MSB recovered from the MSB sum bit
    c_msb = a[W-1] ^ b[W-1] ^ full[W-1];
  end

  assign sum  = full[W-1:0];
  assign cout = full[W];
  assign of   = c_msb ^ full[W];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, carry chain split into STAGES chunks.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B, sub)
//   A, B                 : operands, index 0 is MSB
//   sub                  : 1 = A-B, 0 = A+B
//   out_valid / out_ready: result handshake
//   Sum, cout, of, zero  : registered result and flags, index 0 of Sum is MSB
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] Sum,
  output logic             cout,
  output logic             of,
  output logic             zero
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("addsub_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [WIDTH-1:0] a_le;
  logic [WIDTH-1:0] b_le;
  logic             en;

  // Each stage consumes the low chunk of r and shifts its chunk sum in at the
  // top; after STAGES shifts r holds the full sum in natural bit order.
  logic [WIDTH-1:0] r_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [CHUNK-1:0] fa_sum [STAGES];
  logic             fa_cout[STAGES];
  logic             fa_of;

  logic [WIDTH-1:0] r_d [STAGES], r_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES], b_q [STAGES];
  logic             c_d [STAGES], c_q [STAGES];
  logic             v_d [STAGES], v_q [STAGES];
  status_t          flags_d, flags_q;

  assign a_le     = A;
  assign b_le     = B;
  assign en       = !v_q[LAST] || out_ready;
  assign in_ready = en;

  always_comb begin
    r_in[0] = a_le;
    b_in[0] = sub ? ~b_le : b_le;
    c_in[0] = sub;
    v_in[0] = in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      r_in[s] = r_q[s-1];
      b_in[s] = b_q[s-1];
      c_in[s] = c_q[s-1];
      v_in[s] = v_q[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == LAST) begin : g_last
      fa_nbit #(.W(CHUNK)) u_fa (
        .a    (r_in[s][CHUNK-1:0]),
        .b    (b_in[s][CHUNK-1:0]),
        .cin  (c_in[s]),
        .sum  (fa_sum[s]),
        .cout (fa_cout[s]),
        .of   (fa_of)
      );
    end else begin : g_mid
      logic of_unused;
      fa_nbit #(.W(CHUNK)) u_fa (
        .a    (r_in[s][CHUNK-1:0]),
        .b    (b_in[s][CHUNK-1:0]),
        .cin  (c_in[s]),
        .sum  (fa_sum[s]),
        .cout (fa_cout[s]),
        .of   (of_unused)
      );
    end
  end

  // Data registers load only with a valid beat so bubbles do not toggle them.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      v_d[s] = en ? v_in[s] : v_q[s];
      if (en && v_in[s]) begin
        r_d[s] = (r_in[s] >> CHUNK) | (WIDTH'(fa_sum[s]) << (WIDTH - CHUNK));
        b_d[s] = b_in[s] >> CHUNK;
        c_d[s] = fa_cout[s];
      end else begin
        r_d[s] = r_q[s];
        b_d[s] = b_q[s];
        c_d[s] = c_q[s];
      end
    end
    flags_d = flags_q;
    if (en && v_in[LAST]) begin
      flags_d[FLAG_COUT_BIT] = fa_cout[LAST];
      flags_d[FLAG_OF_BIT]   = fa_of;
      flags_d[FLAG_ZERO_BIT] = (r_d[LAST] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_q[s] <= '0;
        b_q[s] <= '0;
        c_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
      end
      flags_q <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_q[s] <= r_d[s];
        b_q[s] <= b_d[s];
        c_q[s] <= c_d[s];
        v_q[s] <= v_d[s];
      end
      flags_q <= flags_d;
    end
  end

  assign Sum       = r_q[LAST];
  assign out_valid = v_q[LAST];
  assign cout      = flags_q[FLAG_COUT_BIT];
  assign of        = flags_q[FLAG_OF_BIT];
  assign zero      = flags_q[FLAG_ZERO_BIT];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: six parameterisations driven with shared stimulus,
// each scored against an arithmetic reference model.
module tb_addsub_pipe;

  localparam int NI = 6;
  localparam int W_TAB [NI] = '{32, 32, 32, 32, 32, 8};
  localparam int S_TAB [NI] = '{4, 1, 2, 8, 32, 8};

  typedef struct {
    logic [34:0] res;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sub = 1'b0;
  logic [31:0] tb_a = '0;
  logic [31:0] tb_b = '0;

  logic [NI-1:0] ir_w, ov_w, co_w, of_w, z_w;
  logic [31:0]   sum_w [NI];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic lat_chk = 1'b0;
  exp_t exp_q [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int unsigned W = W_TAB[k];
    logic [0:W-1] a_k, b_k, s_k;
    assign a_k = tb_a[W-1:0];
    assign b_k = tb_b[W-1:0];
    addsub_pipe #(.WIDTH(W), .STAGES(S_TAB[k])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir_w[k]),
      .A         (a_k),
      .B         (b_k),
      .sub       (sub),
      .out_valid (ov_w[k]),
      .out_ready (out_ready),
      .Sum       (s_k),
      .cout      (co_w[k]),
      .of        (of_w[k]),
      .zero      (z_w[k])
    );
    assign sum_w[k] = 32'(s_k);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic on w-bit operands.
  function automatic logic [34:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
    longint unsigned m, ua, ub, r;
    longint          sa, sb, sr, lim;
    logic            c, o;
    m   = (64'd1 << w) - 1;
    ua  = a & m;
    ub  = b & m;
    lim = longint'(64'd1 << (w - 1));
    sa  = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
    sb  = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
    if (s) begin
      r  = (ua - ub) & m;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = (ua + ub) & m;
      c  = ((ua + ub) >> w) != 0;
      sr = sa + sb;
    end
    o = (sr >= lim) || (sr < -lim);
    return {32'(r), c, o, (r == 0)};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: every presented result is compared with the oldest accepted beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) exp_q[k].delete();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (ov_w[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("spurious%0d", k), 64'(ov_w[k]), 64'd0);
          end else begin
            chk($sformatf("sb%0d", k), 64'({sum_w[k], co_w[k], of_w[k], z_w[k]}),
                64'(exp_q[k][0].res));
            if (lat_chk) chk($sformatf("lat%0d", k), 64'(cyc - exp_q[k][0].acc), 64'(S_TAB[k]));
            if (out_ready) void'(exp_q[k].pop_front());
          end
        end
        if (in_valid && ir_w[k]) begin
          e.res = ref_model(W_TAB[k], tb_a, tb_b, sub);
          e.acc = cyc;
          exp_q[k].push_back(e);
        end
      end
    end
  end

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [34:0] exp);
    int lat;
    lat = 99;
    @(posedge clk); #1;
    in_valid = 1'b1; tb_a = a; tb_b = b; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ov_w[0]) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk(tag, 64'({sum_w[0], co_w[0], of_w[0], z_w[0]}), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [6];
    logic [31:0] held;
    int          n_ret;
    int          sent;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_out%0d", k), 64'({sum_w[k], co_w[k], of_w[k], z_w[k]}), 64'd0);
      chk($sformatf("rst_vld%0d", k), 64'(ov_w[k]), 64'd0);
      chk($sformatf("rst_rdy%0d", k), 64'(ir_w[k]), 64'd1);
    end

    lat_chk = 1'b1;
    directed("add_1_1",   32'h0000_0001, 32'h0000_0001, 1'b0, {32'h0000_0002, 3'b000});
    directed("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 3'b101});
    directed("ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 3'b010});
    directed("ovf_sub",   32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 3'b110});
    directed("sub_zero",  32'h0000_0005, 32'h0000_0005, 1'b1, {32'h0000_0000, 3'b101});
    directed("sub_borrow",32'h0000_0001, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 3'b000});
    repeat (40) @(posedge clk);

    // Back-to-back beats with a three-cycle output stall.
    lat_chk = 1'b0;
    n_ret   = 0;
    fork
      begin
        for (int i = 0; i < 6; ) begin
          @(posedge clk); #1;
          in_valid = 1'b1; tb_a = 32'(i + 16); tb_b = 32'(i); sub = 1'b0;
          @(negedge clk);
          if (ir_w[0]) i++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov_w[0] && n < 20);
        chk("stall_rise", 64'(ov_w[0]), 64'd1);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        held = sum_w[0];
        chk("stall_rdy", 64'(ir_w[0]), 64'd0);
        for (int j = 1; j < 3; j++) begin
          @(negedge clk);
          chk("stall_rdy", 64'(ir_w[0]), 64'd0);
          chk("stall_vld", 64'(ov_w[0]), 64'd1);
          chk("stall_hold", 64'(sum_w[0]), 64'(held));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 60 && n_ret < 6; c++) begin
          @(negedge clk);
          if (ov_w[0] && out_ready) begin
            got[n_ret] = sum_w[0];
            n_ret++;
          end
        end
      end
    join
    chk("stall_count", 64'(n_ret), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("stall_ord%0d", i), 64'(got[i]), 64'(2 * i + 16));
    repeat (40) @(posedge clk);

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; tb_a = $urandom; tb_b = $urandom; sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("mid_rst_out%0d", k), 64'({sum_w[k], co_w[k], of_w[k], z_w[k]}), 64'd0);
      chk($sformatf("mid_rst_vld%0d", k), 64'(ov_w[k]), 64'd0);
    end
    lat_chk = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", 64'(ov_w[0]), 64'd0);
    end

    // Random beats, no back-pressure: exact latency is checked.
    sent = 0;
    while (sent < 1000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      tb_a = rand_op(); tb_b = rand_op(); sub = 1'($urandom_range(0, 1));
      if (in_valid) sent++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (40) @(posedge clk);

    // Random beats with random back-pressure.
    lat_chk = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tb_a = rand_op(); tb_b = rand_op(); sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("drain%0d", k), 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the execute stage. Wider datapaths close timing by splitting the carry chain into STAGES registered chunks.
- Valid/ready handshake on both sides, so the execute stage can stall it.
- Produces Sum, carry-out, signed overflow and zero flags, matching the flag semantics of the existing ripple adder.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry chunks. Legal range 1..WIDTH; CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- A  input  [0:WIDTH-1]  operand A; index 0 is MSB
- B  input  [0:WIDTH-1]  operand B; index 0 is MSB
- sub  input  1  1: A-B; 0: A+B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- Sum  output  [0:WIDTH-1]  result; index 0 is MSB
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- of  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  Sum == 0

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All valid bits clear; out_valid=0.
  - Sum, cout, of and zero read 0.
  - Pipeline data registers clear.
  - in_ready=1 in the first cycle after reset.
  - A reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Subtract: B is inverted per bit and cin=1. `sub` travels with its beat.
- Pipeline enable:
  - en = !out_valid || out_ready; in_ready = en.
  - All stages advance together when en=1 and hold when en=0 (global stall, no bubble collapsing).
  - A beat is accepted on a cycle with in_valid && in_ready.
- Stage k (k=0..STAGES-1):
  - Adds chunk k, counted from the LSB end, using the carry registered by stage k-1 (stage 0 uses cin).
  - Registers the chunk sum, the carry-out and the valid bit.
  - Operand chunks not yet consumed are delay-registered alongside.
  - Completed lower chunks shift forward with the beat.
- Latency: the result is presented exactly STAGES cycles after acceptance when there is no stall.
- Throughput: one beat per cycle when out_ready is held at 1.
- Output:
  - Sum, cout, of and zero are registered and hold stable while out_valid && !out_ready.
  - of and zero are computed in the final stage from the final chunk's carries and the full Sum.
- Bubbles: an in_valid=0 cycle while en=1 inserts a bubble; the valid bit propagates as 0 and the data is don't-care, but is held at its previous value to reduce toggling.
- Simultaneous events: when out_valid && out_ready && in_valid occur in the same cycle, the output beat retires and the new beat enters stage 0 in that same cycle.
- STAGES=1: single registered adder with latency 1.
- STAGES=WIDTH: 1-bit chunks.
- Wrap-around: arithmetic is modulo 2^WIDTH; cout and of report the wrapped carry and the signed overflow.
- Elaboration: a WIDTH that is not a multiple of STAGES is an elaboration error ($error in a generate check).

Decomposition:
- Shared package addsub_pkg:
  - localparam function for CHUNK.
  - Flag bit-position constants for packing {cout, of, zero} into the status word used by the EX stage.
- Natural sub-module: fa_nbit instantiated with WIDTH=CHUNK, one per stage, using the chunk carry-out (cout) and chunk overflow (of) from the final instance.
- Per-stage registers live in the top module as a generate loop.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1:
  - A=0x00000001, B=0x00000001, sub=0 -> out_valid after 4 cycles; Sum=0x00000002, cout=0, of=0, zero=0.
- Carry across every chunk:
  - A=0xFFFFFFFF, B=0x00000001, sub=0 -> Sum=0x00000000, cout=1, of=0, zero=1.
- Signed overflow and subtract:
  - A=0x7FFFFFFF, B=0x00000001, add -> Sum=0x80000000, of=1, cout=0.
  - A=0x80000000, B=0x00000001, sub -> Sum=0x7FFFFFFF, of=1, cout=1.
- Back-to-back with stall:
  - Drive 6 consecutive beats (i + 0x10, i = 0..5), then hold out_ready=0 for 3 cycles once out_valid rises.
  - Required: in_ready=0 during the stall, the output stays stable, and all 6 results arrive in order with none lost or duplicated.
- Reset mid-flight:
  - Accept 3 beats, assert rst_n=0 for 1 cycle -> out_valid=0 and all outputs 0 next cycle.
  - No stale result emerges during the following 4 cycles with in_valid=0.
- Parameter sweep: STAGES ∈ {1, 2, 8, 32} at WIDTH=32, plus WIDTH=8/STAGES=8, with 1000 random beats vs. a reference model -> exact match; latency = STAGES.
